stage3_load_unit: RTL and testbench

- Execute-side responder for the READRAM8 request that stage12 issues on stage3_read / stage3_read_address.
- Buffers requests, reads one byte from the shared synchronous RAM and writes it into the 512-entry byte register file through a write port.
- Reports completion with a one-cycle done pulse.
- Sits between stage12 and the cpu register file, alongside the ram instance.

---
 rtl/stage3_load_unit_if.sv | 22 ++
 rtl/stage3_load_unit.sv | 150 +++++++++++++++
 tb/tb_stage3_load_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage3_load_unit_if.sv
// Request channel from stage12 to the stage3 load unit: a valid/ready handshake
// that carries the byte address to load and the destination register index.
interface stage3_load_unit_if;
  logic        stage3_read;
  logic [15:0] stage3_read_address;
  logic [8:0]  stage3_read_reg;
  logic        stage3_read_ready;

  modport master (
    output stage3_read,
    output stage3_read_address,
    output stage3_read_reg,
    input  stage3_read_ready
  );

  modport slave (
    input  stage3_read,
    input  stage3_read_address,
    input  stage3_read_reg,
    output stage3_read_ready
  );
endinterface

// File: rtl/stage3_load_unit.sv
// READRAM8 responder: buffers stage12 load requests, reads one RAM byte and writes it to the register file.
// Optional out-of-range load detection against RAM_TOP is enabled by defining STAGE3_FAULT_EN.
module stage3_load_unit #(
  parameter int          DEPTH       = 2,
  parameter int          RAM_LATENCY = 2,
  parameter logic [15:0] RAM_TOP     = 16'hFFFF
) (
  input  logic                ram_clk,
  input  logic                rst,
  stage3_load_unit_if.slave   req,
  output logic [15:0]         ram_address_o,
  output logic                ram_write_enable_o,
  input  logic [7:0]          ram_data_out_i,
  output logic                reg_write_en_o,
  output logic [8:0]          reg_write_index_o,
  output logic [7:0]          reg_write_data_o,
  output logic                stage3_busy_o,
  output logic                stage3_done_o,
  output logic                stage3_fault_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LAT_W = $clog2(RAM_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_FAULT} state_e;

  logic [15:0]      addrMem [DEPTH];
  logic [8:0]       regMem  [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_e           state_q;
  logic [LAT_W-1:0] latCnt_q;
  logic [15:0]      ramAddr_q;
  logic [8:0]       wrIdx_q;
  logic [7:0]       wrData_q;
  logic             wrPulse_q;
  logic             fault_q;

  logic             full, pushEn, popEn, headFault;
  logic [15:0]      headAddr;
  logic [8:0]       headReg;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full                  = (count_q == CNT_W'(DEPTH));
  assign req.stage3_read_ready = !rst && !full;
  assign pushEn                = req.stage3_read && req.stage3_read_ready;
  // WRITE falls through to the IDLE pop so back-to-back loads issue every RAM_LATENCY+2 cycles
  assign popEn                 = (count_q != '0) && ((state_q == S_IDLE) || (state_q == S_WRITE));
  assign headAddr              = addrMem[rdPtr_q];
  assign headReg               = regMem[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
    if (pushEn) wrPtr_d = nextPtr(wrPtr_q);
    if (popEn)  rdPtr_d = nextPtr(rdPtr_q);
  end

  always_ff @(posedge ram_clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge ram_clk) begin
    if (pushEn) begin
      addrMem[wrPtr_q] <= req.stage3_read_address;
      regMem[wrPtr_q]  <= req.stage3_read_reg;
    end
  end

`ifdef STAGE3_FAULT_EN
  assign headFault = (headAddr > RAM_TOP);
`else
  assign headFault = 1'b0;
`endif

  // The counter runs one edge past RAM_LATENCY so the capture edge sees settled RAM data
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      latCnt_q  <= '0;
      ramAddr_q <= '0;
      wrIdx_q   <= '0;
      wrData_q  <= '0;
      wrPulse_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      wrPulse_q <= 1'b0;
      fault_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_WRITE: begin
          state_q <= S_IDLE;
          if (popEn) begin
            if (headFault) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              ramAddr_q <= headAddr;
              wrIdx_q   <= headReg;
              latCnt_q  <= LAT_W'(RAM_LATENCY);
              state_q   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (latCnt_q == '0) begin
            wrData_q  <= ram_data_out_i;
            wrPulse_q <= 1'b1;
            state_q   <= S_WRITE;
          end else begin
            latCnt_q <= latCnt_q - 1'b1;
          end
        end
        S_FAULT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pulses are masked by rst so a reset landing in the WRITE cycle suppresses the write
  assign ram_address_o      = ramAddr_q;
  assign ram_write_enable_o = 1'b0;
  assign reg_write_en_o     = wrPulse_q && !rst;
  assign stage3_done_o      = wrPulse_q && !rst;
  assign reg_write_index_o  = wrIdx_q;
  assign reg_write_data_o   = wrData_q;
  assign stage3_busy_o      = (count_q != '0) || (state_q != S_IDLE);

`ifdef STAGE3_FAULT_EN
  assign stage3_fault_o = fault_q && !rst;
`else
  logic unusedFault;
  assign unusedFault    = fault_q ^ (^RAM_TOP);
  assign stage3_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_stage3_load_unit.sv
// Scoreboard bench for stage3_load_unit: directed loads push expected writes, a negedge monitor checks them.
// Define STAGE3_FAULT_EN to also exercise the out-of-range fault path with RAM_TOP = 16'h00FF.
module tb_stage3_load_unit;

`ifdef STAGE3_FAULT_EN
  localparam logic [15:0] RAM_TOP_TB = 16'h00FF;
`else
  localparam logic [15:0] RAM_TOP_TB = 16'hFFFF;
`endif

  logic        ram_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] ram_address;
  logic        ram_write_enable;
  logic [7:0]  ram_data_out = 8'h00;
  logic        reg_write_en;
  logic [8:0]  reg_write_index;
  logic [7:0]  reg_write_data;
  logic        stage3_busy, stage3_done, stage3_fault;

  stage3_load_unit_if ifc ();

  stage3_load_unit #(.DEPTH(2), .RAM_LATENCY(2), .RAM_TOP(RAM_TOP_TB)) dut (
    .ram_clk            (ram_clk),
    .rst                (rst),
    .req                (ifc.slave),
    .ram_address_o      (ram_address),
    .ram_write_enable_o (ram_write_enable),
    .ram_data_out_i     (ram_data_out),
    .reg_write_en_o     (reg_write_en),
    .reg_write_index_o  (reg_write_index),
    .reg_write_data_o   (reg_write_data),
    .stage3_busy_o      (stage3_busy),
    .stage3_done_o      (stage3_done),
    .stage3_fault_o     (stage3_fault)
  );

  always #5 ram_clk = ~ram_clk;

  // Two-stage registered RAM: data for an address appears two edges after the address
  logic [7:0] ramMem [65536];
  logic [7:0] ramPipe = 8'h00;
  always @(posedge ram_clk) begin
    ramPipe      <= ramMem[ram_address];
    ram_data_out <= ramPipe;
  end

  int cycleCnt = 0;
  always @(posedge ram_clk) cycleCnt <= cycleCnt + 1;

  int          assertCount = 0;
  int          failCount   = 0;
  int          writeCount  = 0;
  int          faultCount  = 0;
  int          lastWriteCycle = 0;
  int          writeCycles[$];
  logic [16:0] expQ[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [8:0] idx,
                               input bit expectWrite, output int accCyc);
    int waited = 0;
    @(negedge ram_clk);
    ifc.stage3_read         = 1'b1;
    ifc.stage3_read_address = addr;
    ifc.stage3_read_reg     = idx;
    while (!ifc.stage3_read_ready && waited < 50) begin
      @(negedge ram_clk);
      waited++;
    end
    accCyc = 0;
    if (!ifc.stage3_read_ready) begin
      checkOutput("acceptTimeout", 0, 1);
    end else begin
      @(posedge ram_clk);
      #1;
      accCyc = cycleCnt;
      if (expectWrite) expQ.push_back({idx, ramMem[addr]});
    end
    ifc.stage3_read = 1'b0;
  endtask

  task automatic waitWrites(input int target, input string name);
    int n = 0;
    while (writeCount < target && n < 200) begin
      @(negedge ram_clk);
      #1;
      n++;
    end
    checkOutput(name, writeCount, target);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge ram_clk);
    #1;
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation
  always @(negedge ram_clk) begin
    logic [16:0] exp;
    if (stage3_fault) faultCount++;
    if (reg_write_en) begin
      writeCount++;
      lastWriteCycle = cycleCnt;
      writeCycles.push_back(cycleCnt);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", 1, 0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("writeIndex", int'(reg_write_index), int'(exp[16:8]));
        checkOutput("writeData", int'(reg_write_data), int'(exp[7:0]));
      end
      checkOutput("doneWithWrite", int'(stage3_done), 1);
      checkOutput("ramWriteEnable", int'(ram_write_enable), 0);
    end else if (stage3_done) begin
      checkOutput("doneWithoutWrite", 1, 0);
    end
  end

  initial begin
    int acc[6];
    int w0;
    for (int i = 0; i < 65536; i++) ramMem[i] = 8'(i * 7 + 3);
    ramMem[16'h0010] = 8'hA5;
    ifc.stage3_read         = 1'b0;
    ifc.stage3_read_address = 16'h0000;
    ifc.stage3_read_reg     = 9'd0;

    // Reset state
    repeat (3) @(posedge ram_clk);
    @(negedge ram_clk);
    checkOutput("readyInReset", int'(ifc.stage3_read_ready), 0);
    checkOutput("busyInReset", int'(stage3_busy), 0);
    checkOutput("ramAddrReset", int'(ram_address), 0);
    checkOutput("regIdxReset", int'(reg_write_index), 0);
    checkOutput("regDataReset", int'(reg_write_data), 0);
    checkOutput("regWenReset", int'(reg_write_en), 0);
    rst = 1'b0;
    #1;
    checkOutput("readyAfterReset", int'(ifc.stage3_read_ready), 1);

    // Single load
    applyStimulus(16'h0010, 9'd5, 1'b1, acc[0]);
    waitWrites(1, "singleLoadWrite");
    checkOutput("singleLatency", lastWriteCycle - acc[0], 4);
    checkOutput("busyDuringWrite", int'(stage3_busy), 1);
    idleCycles(1);
    checkOutput("busyAfterWrite", int'(stage3_busy), 0);

    // Back-to-back, including a held request while the buffer is full and popping
    writeCycles.delete();
    w0 = writeCount;
    for (int i = 0; i < 4; i++) applyStimulus(16'h0020 + 16'(i), 9'(i + 1), 1'b1, acc[i]);
    checkOutput("accept2Cycle", acc[1] - acc[0], 1);
    checkOutput("accept3Cycle", acc[2] - acc[0], 2);
    checkOutput("accept4HeldCycle", acc[3] - acc[0], 6);
    waitWrites(w0 + 4, "backToBackWrites");
    if (writeCycles.size() == 4) begin
      checkOutput("b2bFirstLatency", writeCycles[0] - acc[0], 4);
      for (int i = 1; i < 4; i++) checkOutput("b2bSpacing", writeCycles[i] - writeCycles[i-1], 4);
    end else begin
      checkOutput("b2bWriteCount", writeCycles.size(), 4);
    end
    idleCycles(2);

    // Pointer wrap: six loads into a two-entry buffer
    w0 = writeCount;
    for (int i = 0; i < 6; i++) applyStimulus(16'(i), 9'(500 + i), 1'b1, acc[i]);
    waitWrites(w0 + 6, "wrapWrites");
    idleCycles(2);

    // Reset while WAIT with one entry queued
    w0 = writeCount;
    applyStimulus(16'h0030, 9'd7, 1'b1, acc[0]);
    applyStimulus(16'h0031, 9'd8, 1'b1, acc[1]);
    @(negedge ram_clk);
    rst = 1'b1;
    expQ.delete();
    @(negedge ram_clk);
    checkOutput("busyMidReset", int'(stage3_busy), 0);
    checkOutput("readyMidReset", int'(ifc.stage3_read_ready), 0);
    @(negedge ram_clk);
    rst = 1'b0;
    idleCycles(12);
    checkOutput("noWriteAfterReset", writeCount, w0);
    applyStimulus(16'h0040, 9'd9, 1'b1, acc[0]);
    waitWrites(w0 + 1, "postResetWrite");
    checkOutput("postResetLatency", lastWriteCycle - acc[0], 4);
    idleCycles(2);

`ifdef STAGE3_FAULT_EN
    // Out-of-range load faults without touching RAM or the register file
    w0 = writeCount;
    applyStimulus(16'h0100, 9'd11, 1'b0, acc[0]);
    idleCycles(6);
    checkOutput("faultPulseCount", faultCount, 1);
    checkOutput("faultNoWrite", writeCount, w0);
    checkOutput("faultRamAddrHeld", int'(ram_address), 16'h0040);
    applyStimulus(16'h00FF, 9'd12, 1'b1, acc[0]);
    waitWrites(w0 + 1, "topAddrWrite");
    checkOutput("topAddrLatency", lastWriteCycle - acc[0], 4);
    checkOutput("faultCountFinal", faultCount, 1);
`else
    checkOutput("faultNeverPulses", faultCount, 0);
`endif

    idleCycles(4);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
